uart_tx_param: RTL and testbench

Parametrised UART transmitter, next generation of the team's fixed 8-bit/2-stop transmitter.
- Runs on the system clock, paced by an external oversampling tick enable from the baud generator.
- Serialises one word per frame, LSB first, with runtime-selectable parity (none/even/odd) and 1 or 2 stop bits.
- Uses a ready/start handshake and a one-cycle done pulse. Sits between the TX buffer/control logic and the serial pin.

---
 rtl/uart_tx_param_if.sv | 41 ++++
 rtl/uart_tx_param.sv | 150 +++++++++++++++
 tb/tb_uart_tx_param.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_param_if.sv
// Handshake and serial-line bundle between the TX buffer/control logic
// (master) and the parametrised UART transmitter (slave).
interface uart_tx_param_if #(
    parameter int WIDTH_WORD = 8
);
    logic                  i_tick;
    logic                  i_tx_start;
    logic [WIDTH_WORD-1:0] i_data_in;
    logic [1:0]            i_parity_mode;
    logic                  i_stop_two;
    logic                  o_bit_tx;
    logic                  o_tx_ready;
    logic                  o_tx_busy;
    logic                  o_tx_done;

    // Control side: issues words and pacing ticks, watches line and status.
    modport master (
        output i_tick,
        output i_tx_start,
        output i_data_in,
        output i_parity_mode,
        output i_stop_two,
        input  o_bit_tx,
        input  o_tx_ready,
        input  o_tx_busy,
        input  o_tx_done
    );

    // Transmitter side.
    modport slave (
        input  i_tick,
        input  i_tx_start,
        input  i_data_in,
        input  i_parity_mode,
        input  i_stop_two,
        output o_bit_tx,
        output o_tx_ready,
        output o_tx_busy,
        output o_tx_done
    );
endinterface

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: start bit, WIDTH_WORD data bits LSB first,
// optional even/odd parity, 1 or 2 stop bits. Bit timing is OVERSAMPLE
// ticks of the external tick enable. Line output is registered, idle high.
module uart_tx_param #(
    parameter int WIDTH_WORD = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic           i_clock,
    input  logic           i_reset,
    uart_tx_param_if.slave bus
);
    localparam int CW = $clog2(OVERSAMPLE);
    localparam int IW = $clog2(WIDTH_WORD);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t                state_reg;
    state_t                state_next;
    logic [CW-1:0]         tick_cnt_reg;
    logic [IW-1:0]         idx_reg;
    logic [IW-1:0]         idx_plus;
    logic                  stop_cnt_reg;
    logic [WIDTH_WORD-1:0] shadow_reg;
    logic [1:0]            mode_reg;
    logic                  stop_two_reg;
    logic                  parity_bit_reg;
    logic                  bit_reg;
    logic                  bit_next;
    logic                  done_reg;
    logic                  done_next;

    logic accept;
    logic busy;
    logic bit_end;
    logic last_data;
    logic last_stop;
    logic use_parity;
    logic parity_calc;

    assign accept      = (state_reg == IDLE) && bus.i_tx_start;
    assign busy        = (state_reg != IDLE);
    assign bit_end     = bus.i_tick && (tick_cnt_reg == CW'(OVERSAMPLE - 1));
    assign last_data   = (idx_reg == IW'(WIDTH_WORD - 1));
    // Second stop bit is only needed when two were requested at acceptance.
    assign last_stop   = (stop_cnt_reg == stop_two_reg);
    assign use_parity  = (mode_reg == 2'b01) || (mode_reg == 2'b10);
    assign idx_plus    = idx_reg + IW'(1);
    // Even parity is the XOR of the word; odd parity is its inverse.
    assign parity_calc = (^bus.i_data_in) ^ (bus.i_parity_mode == 2'b10);

    // State register plus the registered line and done outputs.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_reg <= IDLE;
            bit_reg   <= 1'b1;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            bit_reg   <= bit_next;
            done_reg  <= done_next;
        end
    end

    // Next-state logic: every transition other than acceptance happens at a bit end.
    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            IDLE:    if (bus.i_tx_start) state_next = START;
            START:   if (bit_end) state_next = DATA;
            DATA:    if (bit_end && last_data) state_next = use_parity ? PARITY : STOP;
            PARITY:  if (bit_end) state_next = STOP;
            STOP:    if (bit_end && last_stop) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output logic: value the line takes for the next bit, and the frame-end pulse.
    always_comb begin
        bit_next  = bit_reg;
        done_next = 1'b0;
        unique case (state_reg)
            IDLE: begin
                if (bus.i_tx_start) bit_next = 1'b0;
            end
            START: begin
                if (bit_end) bit_next = shadow_reg[0];
            end
            DATA: begin
                if (bit_end) begin
                    if (!last_data)     bit_next = shadow_reg[idx_plus];
                    else if (use_parity) bit_next = parity_bit_reg;
                    else                 bit_next = 1'b1;
                end
            end
            PARITY: begin
                if (bit_end) bit_next = 1'b1;
            end
            STOP: begin
                bit_next = 1'b1;
                if (bit_end && last_stop) done_next = 1'b1;
            end
            default: begin
                bit_next = 1'b1;
            end
        endcase
    end

    // Datapath: shadow latches at acceptance, tick/bit/stop counters while busy.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            tick_cnt_reg   <= '0;
            idx_reg        <= '0;
            stop_cnt_reg   <= 1'b0;
            shadow_reg     <= '0;
            mode_reg       <= '0;
            stop_two_reg   <= 1'b0;
            parity_bit_reg <= 1'b0;
        end else if (accept) begin
            // A tick coincident with acceptance is deliberately dropped.
            tick_cnt_reg   <= '0;
            idx_reg        <= '0;
            stop_cnt_reg   <= 1'b0;
            shadow_reg     <= bus.i_data_in;
            mode_reg       <= bus.i_parity_mode;
            stop_two_reg   <= bus.i_stop_two;
            parity_bit_reg <= parity_calc;
        end else if (busy && bus.i_tick) begin
            tick_cnt_reg <= bit_end ? '0 : tick_cnt_reg + 1'b1;
            if (bit_end) begin
                unique case (state_reg)
                    START:   idx_reg <= '0;
                    DATA:    if (!last_data) idx_reg <= idx_plus;
                    STOP:    if (!last_stop) stop_cnt_reg <= 1'b1;
                    default: ;
                endcase
            end
        end
    end

    assign bus.o_bit_tx   = bit_reg;
    assign bus.o_tx_ready = (state_reg == IDLE);
    assign bus.o_tx_busy  = busy;
    assign bus.o_tx_done  = done_reg;
endmodule

// File: tb/tb_uart_tx_param.sv
// Directed bench for uart_tx_param: an 8-bit/16x instance and a 5-bit/8x
// instance, one tick every 4 clocks, hand-written expected line sequences.
module tb_uart_tx_param;
    logic clk;
    logic rst_n;
    int   checks  = 0;
    int   errors  = 0;
    int   done_cnt8 = 0;
    int   done_cnt5 = 0;
    int   base;

    uart_tx_param_if #(.WIDTH_WORD(8)) bus8 ();
    uart_tx_param_if #(.WIDTH_WORD(5)) bus5 ();

    uart_tx_param #(.WIDTH_WORD(8), .OVERSAMPLE(16)) dut8 (
        .i_clock (clk),
        .i_reset (rst_n),
        .bus     (bus8)
    );

    uart_tx_param #(.WIDTH_WORD(5), .OVERSAMPLE(8)) dut5 (
        .i_clock (clk),
        .i_reset (rst_n),
        .bus     (bus5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count done pulses independently of the directed checks.
    always @(posedge clk) begin
        done_cnt8 <= done_cnt8 + int'(bus8.o_tx_done);
        done_cnt5 <= done_cnt5 + int'(bus5.o_tx_done);
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, required normal finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic line_of(input int sel);
        return (sel != 0) ? bus5.o_bit_tx : bus8.o_bit_tx;
    endfunction
    function automatic logic busy_of(input int sel);
        return (sel != 0) ? bus5.o_tx_busy : bus8.o_tx_busy;
    endfunction
    function automatic logic ready_of(input int sel);
        return (sel != 0) ? bus5.o_tx_ready : bus8.o_tx_ready;
    endfunction
    function automatic logic done_of(input int sel);
        return (sel != 0) ? bus5.o_tx_done : bus8.o_tx_done;
    endfunction

    // n ticks, one every 4 clocks; returns on the negedge right after the last tick's edge.
    task automatic tick_n(input int n);
        repeat (n) begin
            repeat (3) @(negedge clk);
            bus8.i_tick = 1'b1;
            bus5.i_tick = 1'b1;
            @(negedge clk);
            bus8.i_tick = 1'b0;
            bus5.i_tick = 1'b0;
        end
    endtask

    task automatic start8(input logic [7:0] data, input logic [1:0] mode, input logic stop2);
        bus8.i_data_in     = data;
        bus8.i_parity_mode = mode;
        bus8.i_stop_two    = stop2;
        bus8.i_tx_start    = 1'b1;
        @(negedge clk);
        bus8.i_tx_start    = 1'b0;
    endtask

    // Called on the negedge after the accepting edge; bits[0] is the start bit.
    task automatic check_frame(input string tag, input logic [15:0] bits, input int nbits,
                               input int tpb, input int sel);
        for (int b = 0; b < nbits; b++) begin
            tick_n(tpb - 1);
            chk($sformatf("%s bit%0d end line", tag, b), line_of(sel), bits[b]);
            chk($sformatf("%s bit%0d busy", tag, b), busy_of(sel), 1'b1);
            tick_n(1);
            if (b < nbits - 1) begin
                chk($sformatf("%s bit%0d start line", tag, b + 1), line_of(sel), bits[b + 1]);
            end else begin
                chk($sformatf("%s done pulse", tag), done_of(sel), 1'b1);
                chk($sformatf("%s busy at end", tag), busy_of(sel), 1'b0);
                chk($sformatf("%s ready at end", tag), ready_of(sel), 1'b1);
                chk($sformatf("%s line at end", tag), line_of(sel), 1'b1);
            end
        end
        @(negedge clk);
        chk($sformatf("%s done one cycle", tag), done_of(sel), 1'b0);
        $display("frame %s: %0d bits of %0d ticks sent", tag, nbits, tpb);
    endtask

    initial begin
        rst_n = 1'b0;
        bus8.i_tick = 1'b0; bus8.i_tx_start = 1'b0; bus8.i_data_in = '0;
        bus8.i_parity_mode = 2'b00; bus8.i_stop_two = 1'b0;
        bus5.i_tick = 1'b0; bus5.i_tx_start = 1'b0; bus5.i_data_in = '0;
        bus5.i_parity_mode = 2'b00; bus5.i_stop_two = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state of both instances.
        chk("reset line8", bus8.o_bit_tx, 1'b1);
        chk("reset ready8", bus8.o_tx_ready, 1'b1);
        chk("reset busy8", bus8.o_tx_busy, 1'b0);
        chk("reset done8", bus8.o_tx_done, 1'b0);
        chk("reset line5", bus5.o_bit_tx, 1'b1);
        chk("reset ready5", bus5.o_tx_ready, 1'b1);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: 0x55, no parity, 1 stop -> 0,1,0,1,0,1,0,1,0,1.
        base = done_cnt8;
        start8(8'h55, 2'b00, 1'b0);
        chk("t1 accept line", bus8.o_bit_tx, 1'b0);
        chk("t1 accept busy", bus8.o_tx_busy, 1'b1);
        chk("t1 accept ready", bus8.o_tx_ready, 1'b0);
        check_frame("t1", 16'b1_01010101_0, 10, 16, 0);
        chk("t1 done count", done_cnt8 - base, 1);

        // 2: 0xA7 even parity (bit 1), 2 stops; then odd parity (bit 0).
        start8(8'hA7, 2'b01, 1'b1);
        check_frame("t2 even", 16'b11_1_10100111_0, 12, 16, 0);
        start8(8'hA7, 2'b10, 1'b1);
        check_frame("t2 odd", 16'b11_0_10100111_0, 12, 16, 0);

        // 3: start and data change while busy are ignored. 0x3C: d1=0, d4=1.
        base = done_cnt8;
        start8(8'h3C, 2'b00, 1'b0);
        tick_n(40);
        bus8.i_data_in  = 8'h00;
        bus8.i_tx_start = 1'b1;
        @(negedge clk);
        bus8.i_tx_start = 1'b0;
        chk("t3 tick40 line", bus8.o_bit_tx, 1'b0);
        chk("t3 tick40 busy", bus8.o_tx_busy, 1'b1);
        tick_n(48);
        chk("t3 tick88 line", bus8.o_bit_tx, 1'b1);
        tick_n(71);
        chk("t3 tick159 done", bus8.o_tx_done, 1'b0);
        chk("t3 tick159 busy", bus8.o_tx_busy, 1'b1);
        tick_n(1);
        chk("t3 tick160 done", bus8.o_tx_done, 1'b1);
        @(negedge clk);
        tick_n(20);
        chk("t3 idle busy", bus8.o_tx_busy, 1'b0);
        chk("t3 idle line", bus8.o_bit_tx, 1'b1);
        chk("t3 done count", done_cnt8 - base, 1);
        $display("frame t3: data change and restart ignored while busy");

        // 4: start held high, 0x0F -> back-to-back frames one clock apart.
        base = done_cnt8;
        bus8.i_data_in = 8'h0F; bus8.i_parity_mode = 2'b00; bus8.i_stop_two = 1'b0;
        bus8.i_tx_start = 1'b1;
        @(negedge clk);
        check_frame("t4 first", 16'b1_00001111_0, 10, 16, 0);
        chk("t4 second start line", bus8.o_bit_tx, 1'b0);
        chk("t4 second start busy", bus8.o_tx_busy, 1'b1);
        bus8.i_tx_start = 1'b0;
        check_frame("t4 second", 16'b1_00001111_0, 10, 16, 0);
        chk("t4 done count", done_cnt8 - base, 2);

        // 5: asynchronous reset during data bit 3 of 0xA7 (d3=0), then fresh frame.
        base = done_cnt8;
        start8(8'hA7, 2'b01, 1'b1);
        tick_n(70);
        chk("t5 bit3 line", bus8.o_bit_tx, 1'b0);
        #1 rst_n = 1'b0;
        #1;
        chk("t5 async line", bus8.o_bit_tx, 1'b1);
        chk("t5 async busy", bus8.o_tx_busy, 1'b0);
        chk("t5 async ready", bus8.o_tx_ready, 1'b1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        tick_n(20);
        chk("t5 no resume line", bus8.o_bit_tx, 1'b1);
        chk("t5 no resume busy", bus8.o_tx_busy, 1'b0);
        chk("t5 no done", done_cnt8 - base, 0);
        start8(8'h55, 2'b00, 1'b0);
        check_frame("t5 fresh", 16'b1_01010101_0, 10, 16, 0);

        // 6: 5-bit/8x instance, 0x13 odd parity -> 1,1,0,0,1, parity 0, 1 stop.
        base = done_cnt5;
        bus5.i_data_in = 5'h13; bus5.i_parity_mode = 2'b10; bus5.i_stop_two = 1'b0;
        bus5.i_tx_start = 1'b1;
        @(negedge clk);
        bus5.i_tx_start = 1'b0;
        repeat (20) @(negedge clk);
        chk("t6 no tick line", bus5.o_bit_tx, 1'b0);
        chk("t6 no tick busy", bus5.o_tx_busy, 1'b1);
        check_frame("t6", 16'b1_0_10011_0, 8, 8, 1);
        chk("t6 done count", done_cnt5 - base, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
